rf_pkt_tx: RTL and testbench
============================

# rf_pkt_tx

Transmit-side framer for the RF pulse link. It serializes a 64-bit packet onto `rf_out` as an 8-pulse timing preamble followed by 64 OOK bit slots, all on a fixed slot period. The far-end receiver recovers slot timing from the preamble and strobes its shift register at mid-slot. The block sits between the packet source (controller/register file) and the RF front-end driver, and is active only while the link is in TX mode (`RX`=0).

## Interface
- `PERIOD`, 10000: slot length in clk cycles (1 ms at 10 MHz); ≥ 2*`PULSE_W`.
- `PULSE_W`, 100: preamble pulse width in cycles; ≥ 1.
- `PREAMBLE`, 8: number of preamble slots.
- `PACKET`, 64: data bits per packet; equals the `data_in` width.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  link direction; 1 = receive mode. Any transmit is inhibited or aborted.
- `start`  in  1  request to send; sampled only in IDLE.
- `data_in`  in  `PACKET`  packet, MSB sent first; captured on the accepted `start` cycle.
- `rf_out`  out  1  modulated line to the RF driver.
- `tx_rdy`  out  1  one-cycle strobe at the first cycle of preamble slot 0.
- `busy`  out  1  high from acceptance until completion or abort.
- `done`  out  1  one-cycle strobe after the last data slot.
- `aborted`  out  1  one-cycle strobe when `RX` kills a transfer.

## Operation
- Outputs are registered. Reset values: `rf_out`=0, `tx_rdy`=0, `busy`=0, `done`=0, `aborted`=0. State is IDLE and all counters and the shift register are 0.
- **State IDLE**
  - `start`=1 and `RX`=0: load `shreg`←`data_in`, `slot_cnt`←0, `bit_cnt`←0, go to PREAMBLE.
  - `start` with `RX`=1: ignored.
- **State PREAMBLE**
  - `rf_out`=1 while `slot_cnt` < `PULSE_W`, otherwise 0.
  - `slot_cnt` counts 0..`PERIOD`-1 and wraps to 0. Each wrap increments `bit_cnt`.
  - At the wrap with `bit_cnt`=`PREAMBLE`-1: `bit_cnt`←0, go to DATA.
- **State DATA**
  - `rf_out`=`shreg[PACKET-1]` for the whole slot (level OOK).
  - At slot wrap: `shreg`←`shreg`<<1 (zero fill) and `bit_cnt`+1.
  - At the wrap with `bit_cnt`=`PACKET`-1: go to DONE.
- **State DONE**
  - One cycle: `done`=1, `rf_out`=0, `busy`=0, then go to IDLE.
- **Abort**
  - `RX`=1 in PREAMBLE or DATA, on any cycle: next cycle `rf_out`=0, `aborted`=1 for one cycle, `busy`=0, state IDLE, counters cleared. `done` is not pulsed.
- `start` while `busy`=1 is ignored, not queued.
- Width rules:
  - `slot_cnt` is $clog2(`PERIOD`) bits, compared against `PERIOD`-1 (no overflow wrap).
  - `bit_cnt` is $clog2(max(`PREAMBLE`,`PACKET`))+1 bits.
- Reset mid-transfer: all outputs go to reset values immediately (async). No partial frame resumes.

## Timing
- `start` accepted at edge N: in cycle N+1, `busy`=1, `tx_rdy`=1 and `rf_out`=1 (preamble pulse 0, first cycle).
- Preamble pulse k rises at cycle N+1+k·`PERIOD` and lasts `PULSE_W` cycles.
- Data bit i (i=0 is the MSB) occupies cycles N+1+(`PREAMBLE`+i)·`PERIOD` through +`PERIOD`-1.
- `done` is high at cycle N+1+(`PREAMBLE`+`PACKET`)·`PERIOD`. IDLE follows, and a new `start` is accepted on the next edge (back-to-back gap of 1 cycle).
- Total frame time is (`PREAMBLE`+`PACKET`)·`PERIOD`+1 cycles; 720001 cycles with default parameters.
- `RX` is assumed synchronous to `clk` (the mode controller is in the same domain). Abort latency is 1 cycle.

## Test plan
- **Reset:** assert `rst`=0 mid-DATA. Then `rf_out`, `busy`, `done`, `tx_rdy` and `aborted` are all 0 asynchronously, and the block is IDLE after release.
- **Nominal frame**, `PERIOD`=20, `PULSE_W`=4, `data_in`=64'hA5A5_0000_FFFF_8001:
  - 8 pulses, each 4 cycles high and 16 low.
  - Then 64 slots of 20 cycles matching the bits MSB-first.
  - `done` at start+1+1440.
- **Start while busy:** pulse `start` with new data during preamble slot 3. Transmitted bits still equal the first `data_in`, and only one `done` occurs.
- **Abort:** raise `RX` at data slot 10, cycle 7.
  - Next cycle: `rf_out`=0, `aborted`=1 for 1 cycle, `busy`=0, no `done`.
  - A subsequent `start` with `RX`=0 transmits a full frame.
- **RX gating:** `start`=1 with `RX`=1 leaves `busy` and `rf_out` at 0 and `tx_rdy` never pulses.
- **Back-to-back:** hold `start`=1 continuously with `data_in`=all-ones then all-zeros. Frames are separated by exactly one IDLE cycle, and `tx_rdy` pulses once per frame.

Source files
------------

// File: rtl/rf_pkt_tx.sv
// rf_pkt_tx: RF pulse-link transmit framer.
// Sends PREAMBLE timing pulses (PULSE_W high within each PERIOD-cycle slot),
// then PACKET level-OOK data slots MSB first, then a one-cycle done strobe.
// RX=1 during a frame aborts it on the next cycle. All outputs are registered
// and computed from the values the counters take on the same edge, so rf_out
// lines up exactly with the slot the counters are in.
module rf_pkt_tx #(
    parameter int PERIOD   = 10000,
    parameter int PULSE_W  = 100,
    parameter int PREAMBLE = 8,
    parameter int PACKET   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    input  logic              start,
    input  logic [PACKET-1:0] data_in,
    output logic              rf_out,
    output logic              tx_rdy,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int SLOT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int MAX_LEN = (PREAMBLE > PACKET) ? PREAMBLE : PACKET;
    localparam int BIT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD - 1);
    localparam logic [SLOT_W-1:0] PULSE_END = SLOT_W'(PULSE_W - 1);
    localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'(PREAMBLE - 1);
    localparam logic [BIT_W-1:0]  PKT_LAST  = BIT_W'(PACKET - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DONE
    } state_t;

    state_t            state;
    logic [SLOT_W-1:0] slot_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PACKET-1:0] shreg;

    logic slot_wrap;
    logic pulse_next;
    logic in_frame;

    // Slot end detection, and whether the next preamble cycle is inside the pulse
    // (the slot position after this edge is slot_cnt+1, or 0 on a wrap).
    always_comb begin
        slot_wrap  = (slot_cnt == SLOT_LAST);
        pulse_next = slot_wrap | (slot_cnt < PULSE_END);
        in_frame   = (state == S_PRE) || (state == S_DATA);
    end

    // Framer state machine with registered line and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            slot_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rf_out   <= 1'b0;
            tx_rdy   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            tx_rdy  <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            if (in_frame && RX) begin
                // Receive mode kills the frame; nothing partial is resumed later.
                state    <= S_IDLE;
                slot_cnt <= '0;
                bit_cnt  <= '0;
                rf_out   <= 1'b0;
                busy     <= 1'b0;
                aborted  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        rf_out <= 1'b0;
                        busy   <= 1'b0;
                        if (start && !RX) begin
                            shreg    <= data_in;
                            slot_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= S_PRE;
                            rf_out   <= 1'b1;
                            busy     <= 1'b1;
                            tx_rdy   <= 1'b1;
                        end
                    end
                    S_PRE: begin
                        slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
                        if (slot_wrap && (bit_cnt == PRE_LAST)) begin
                            bit_cnt <= '0;
                            state   <= S_DATA;
                            rf_out  <= shreg[PACKET-1];
                        end else begin
                            if (slot_wrap) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                            rf_out <= pulse_next;
                        end
                    end
                    S_DATA: begin
                        if (slot_wrap) begin
                            slot_cnt <= '0;
                            shreg    <= shreg << 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == PKT_LAST) begin
                                bit_cnt <= '0;
                                state   <= S_DONE;
                                rf_out  <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                // Next bit is the one about to shift into the MSB.
                                rf_out <= shreg[PACKET-2];
                            end
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                            rf_out   <= shreg[PACKET-1];
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        rf_out <= 1'b0;
                        busy   <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        rf_out <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rf_pkt_tx.sv
// Testbench for rf_pkt_tx with a short slot period.
// A negedge monitor compares every cycle against a scoreboard queue of expected
// outputs built from the frame timing when a start is accepted.
module tb_rf_pkt_tx;

    localparam int P     = 20;
    localparam int PW    = 4;
    localparam int NPRE  = 8;
    localparam int NPKT  = 64;
    localparam int FRAME = (NPRE + NPKT) * P + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RX = 1'b0;
    logic        start = 1'b0;
    logic [63:0] data_in = '0;
    logic        rf_out, tx_rdy, busy, done, aborted;

    rf_pkt_tx #(
        .PERIOD  (P),
        .PULSE_W (PW),
        .PREAMBLE(NPRE),
        .PACKET  (NPKT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .RX     (RX),
        .start  (start),
        .data_in(data_in),
        .rf_out (rf_out),
        .tx_rdy (tx_rdy),
        .busy   (busy),
        .done   (done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rf;
        logic busy;
        logic txr;
        logic done;
        logic abt;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic        rx_start;
        int          abort_at;
        int          exp_done;
        int          exp_abort;
        int          exp_txr;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_idle;
    logic exp_abt_next = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   cnt_done = 0;
    int   cnt_abort = 0;
    int   cnt_txr = 0;
    int   txr_last = 0;
    int   txr_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected per-cycle outputs for a frame accepted with data d.
    function automatic void push_frame(input logic [63:0] d);
        exp_t e;
        int   slot;
        int   off;
        for (int j = 0; j < FRAME; j++) begin
            e    = '0;
            slot = j / P;
            off  = j % P;
            if (j == FRAME - 1) begin
                e.done = 1'b1;
            end else begin
                e.busy = 1'b1;
                e.txr  = (j == 0);
                if (slot < NPRE) e.rf = (off < PW);
                else             e.rf = d[NPKT-1-(slot-NPRE)];
            end
            sb.push_back(e);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle scoreboard compare and acceptance/abort tracking.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_abt_next = 1'b0;
        end else begin
            if (sb.size() == 0) begin
                mon_e     = '0;
                mon_e.abt = exp_abt_next;
                mon_idle  = 1'b1;
            end else begin
                mon_e    = sb.pop_front();
                mon_idle = 1'b0;
            end
            exp_abt_next = 1'b0;
            check($sformatf("out@%0d", cyc), {59'd0, rf_out, busy, tx_rdy, done, aborted},
                  {59'd0, mon_e});
            if (done)    cnt_done++;
            if (aborted) cnt_abort++;
            if (tx_rdy) begin
                cnt_txr++;
                txr_prev = txr_last;
                txr_last = cyc;
            end
            if (mon_idle) begin
                if (start && !RX) push_frame(data_in);
            end else if (!mon_e.done && RX) begin
                sb.delete();
                exp_abt_next = 1'b1;
            end
        end
    end

    task automatic wait_frame_end(input string name);
        for (int k = 0; k < FRAME + 20; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check(name, sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int d0, a0, t0;
        d0 = cnt_done; a0 = cnt_abort; t0 = cnt_txr;
        @(posedge clk); #1;
        start = 1'b1; data_in = v.data; RX = v.rx_start;
        @(posedge clk); #1;
        start = 1'b0; data_in = {$urandom, $urandom};
        if (v.rx_start) begin
            repeat (5) @(posedge clk);
            #1;
            check($sformatf("v%0d_gate_busy", idx), busy, 0);
            RX = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end else if (v.abort_at >= 0) begin
            repeat (v.abort_at) @(posedge clk);
            #1;
            RX = 1'b1;
            @(posedge clk); #1;
            RX = 1'b0;
            check($sformatf("v%0d_abort_rf", idx), rf_out, 0);
            check($sformatf("v%0d_abort_busy", idx), busy, 0);
            repeat (4) @(posedge clk);
            #1;
        end else begin
            wait_frame_end($sformatf("v%0d_end", idx));
        end
        check($sformatf("v%0d_done_cnt", idx), cnt_done - d0, v.exp_done);
        check($sformatf("v%0d_abort_cnt", idx), cnt_abort - a0, v.exp_abort);
        check($sformatf("v%0d_txrdy_cnt", idx), cnt_txr - t0, v.exp_txr);
    endtask

    vec_t vecs[6];

    initial begin
        int d0, t0;
        vecs[0] = '{64'hA5A5_0000_FFFF_8001, 1'b0, -1, 1, 0, 1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, 0, 0, 0};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 1'b0, (NPRE + 10) * P + 7, 0, 1, 1};
        vecs[3] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b0, -1, 1, 0, 1};
        vecs[4] = '{64'h8000_0000_0000_0001, 1'b0, 2 * P + 5, 0, 1, 1};
        vecs[5] = '{64'h0000_0000_0000_0000, 1'b0, -1, 1, 0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rf_out", rf_out, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_rdy", tx_rdy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Start while busy: second request during preamble slot 3 is dropped.
        d0 = cnt_done; t0 = cnt_txr;
        start = 1'b1; data_in = 64'h1357_9BDF_2468_ACE0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3 * P + 5) @(posedge clk);
        #1;
        start = 1'b1; data_in = 64'hECA8_6420_FDB9_7531;
        @(posedge clk); #1;
        start = 1'b0;
        wait_frame_end("busy_end");
        check("busy_done_cnt", cnt_done - d0, 1);
        check("busy_txrdy_cnt", cnt_txr - t0, 1);

        // Back-to-back with start held high.
        d0 = cnt_done; t0 = cnt_txr;
        start = 1'b1; data_in = '1;
        @(posedge clk); #1;
        data_in = '0;
        for (int k = 0; k < 2 * FRAME + 20; k++) begin
            if (cnt_txr - t0 >= 2) break;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        check("b2b_second_start", cnt_txr - t0, 2);
        check("b2b_txrdy_gap", txr_last - txr_prev, FRAME + 1);
        wait_frame_end("b2b_end");
        check("b2b_done_cnt", cnt_done - d0, 2);
        check("b2b_txrdy_cnt", cnt_txr - t0, 2);

        // Asynchronous reset in the middle of the data phase.
        start = 1'b1; data_in = 64'hF0F0_F0F0_0F0F_0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat ((NPRE + 5) * P + 3) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("async_rst_out", {rf_out, busy, tx_rdy, done, aborted}, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        d0 = cnt_done;
        start = 1'b1; data_in = 64'h0F1E_2D3C_4B5A_6978;
        @(posedge clk); #1;
        start = 1'b0;
        wait_frame_end("post_rst_end");
        check("post_rst_done_cnt", cnt_done - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
